// File: rtl/mp_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mp_add_seq / cla16                                              |
// | Function : multi-precision add/subtract, one 16-bit CLA slice per cycle   |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+

module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);

    // 4-bit lookahead unit, returns carries c[4:0] with c[0] = c0.
    function automatic logic [4:0] lah(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | ((&p) & c0);
        return c;
    endfunction

    logic [15:0] w_g, w_p, w_c;
    logic [3:0]  w_gg, w_gp, w_gc;
    logic [4:0]  w_t;

    always_comb begin
        w_g  = a & b;
        w_p  = a ^ b;
        w_gg = '0;
        w_gp = '0;
        w_gc = '0;
        w_c  = '0;
        w_t  = '0;
        for (int j = 0; j < 4; j++) begin
            w_t     = lah(w_g[4*j +: 4], w_p[4*j +: 4], 1'b0);
            w_gg[j] = w_t[4];
            w_gp[j] = &w_p[4*j +: 4];
        end
        w_t  = lah(w_gg, w_gp, ci);
        w_gc = w_t[3:0];
        co   = w_t[4];
        for (int j = 0; j < 4; j++) begin
            w_t            = lah(w_g[4*j +: 4], w_p[4*j +: 4], w_gc[j]);
            w_c[4*j +: 4]  = w_t[3:0];
        end
        s = w_p ^ w_c;
    end

endmodule

module mp_add_seq #(
    parameter int NWORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [16*NWORDS-1:0]  a,
    input  logic [16*NWORDS-1:0]  b,
    output logic                  busy,
    output logic                  done,
    output logic [16*NWORDS-1:0]  sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W  = 16 * NWORDS;
    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic            sub_q, sub_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            cout_q, cout_d, ovf_q, ovf_d;

    logic [15:0]     w_a_sl, w_b_sl, w_bp, w_s;
    logic            w_co;

    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (k_q == KW'(i)) begin
                w_a_sl = a_q[16*i +: 16];
                w_b_sl = b_q[16*i +: 16];
            end
        end
        w_bp = sub_q ? ~w_b_sl : w_b_sl;
    end

    cla16 u_cla (
        .a  (w_a_sl),
        .b  (w_bp),
        .ci (carry_q),
        .s  (w_s),
        .co (w_co)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            RUN: begin
                for (int i = 0; i < NWORDS; i++) begin
                    if (k_q == KW'(i)) sum_d[16*i +: 16] = w_s;
                end
                carry_d = w_co;
                k_d     = k_q + KW'(1);
                if (k_q == KW'(NWORDS - 1)) begin
                    state_d = DONE;
                    cout_d  = w_co;
                    // Sign bits of the top slice decide signed overflow.
                    ovf_d   = (w_a_sl[15] == w_bp[15]) && (w_s[15] != w_a_sl[15]);
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    sum_d   = '0;
                    k_d     = '0;
                    carry_d = sub;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mp_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mp_add_seq                                                   |
// | Function : directed vector bench for mp_add_seq (NWORDS = 4)               |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+

module tb_mp_add_seq;

    localparam int NW = 4;
    localparam int W  = 16 * NW;
    localparam int NV = 11;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    mp_add_seq #(.NWORDS(NW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs [NV];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
        @(negedge clk);
        a = va; b = vb; sub = vs; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        int guard;
        nbusy = 0;
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            guard++;
        end
    endtask

    initial begin
        int nb, last, np;
        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[2]  = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[3]  = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
        vecs[4]  = '{64'h0000_0C28_0000_0C28, 64'h4CBA_4CBA_4CBA_4CBA, 1'b0,
                     64'h4CBA_58E2_4CBA_58E2, 1'b0, 1'b0};
        vecs[5]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[6]  = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[7]  = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[8]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[9]  = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
                     64'h2345_6789_ABCD_F001, 1'b0, 1'b0};
        vecs[10] = '{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

        // Asynchronous reset at power-up.
        #1 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum",  sum,  0);
        check("rst_cout", cout, 0);
        check("rst_ovf",  ovf,  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
            wait_done(nb);
            check($sformatf("v%0d_done", i),  done, 1);
            check($sformatf("v%0d_nbusy", i), nb, 4);
            check($sformatf("v%0d_sum", i),   sum, vecs[i].s);
            check($sformatf("v%0d_cout", i),  cout, vecs[i].co);
            check($sformatf("v%0d_ovf", i),   ovf, vecs[i].ov);
            @(negedge clk);
            check($sformatf("v%0d_done_1cyc", i), {busy, done}, 0);
            check($sformatf("v%0d_hold", i),      sum, vecs[i].s);
        end

        // Start pulsed while busy must be ignored.
        start_op(vecs[4].a, vecs[4].b, 1'b0);
        a = 64'h1111_2222_3333_4444; b = 64'h9999_8888_7777_6666; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb);
        check("ign_nbusy", nb + 1, 4);
        check("ign_sum",   sum, vecs[4].s);
        check("ign_cout",  cout, 0);
        check("ign_ovf",   ovf, 0);

        // Asynchronous reset on the second busy cycle.
        start_op(vecs[9].a, vecs[9].b, 1'b0);
        @(negedge clk);
        check("mid_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sum",  sum,  0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ovf",  ovf,  0);
        @(negedge clk);
        rst = 1'b0;
        start_op(vecs[1].a, vecs[1].b, 1'b0);
        wait_done(nb);
        check("post_rst_nbusy", nb, 4);
        check("post_rst_sum",   sum, vecs[1].s);
        check("post_rst_ovf",   ovf, 1);
        @(negedge clk);

        // Start held high: back-to-back operations every 5 cycles.
        a = vecs[9].a; b = vecs[9].b; sub = 1'b0; start = 1'b1;
        last = -1;
        np = 0;
        for (int cyc = 0; cyc < 30 && np < 3; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                check($sformatf("b2b_sum%0d", np), sum, vecs[9].s);
                if (last >= 0) check($sformatf("b2b_period%0d", np), cyc - last, 5);
                last = cyc;
                np++;
            end
        end
        check("b2b_pulses", np, 3);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("b2b_idle", {busy, done}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
